// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Purpose  : UART receiver. Deserializes the rx line using the runtime bit
//            period and frame format, and presents each byte with parity and
//            framing flags on a one-entry valid/ready output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_core #(
    parameter int DATA_BITS = 8,
    parameter int MIN_DIV   = 4
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 clk_en_i,
    input  logic [31:0]          clk_div_i,
    input  logic                 parity_en_i,
    input  logic                 parity_type_i,
    input  logic                 stop_bits_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_PARITY    = 3'd3;
    localparam logic [2:0] c_ST_STOP1     = 3'd4;
    localparam logic [2:0] c_ST_STOP2     = 3'd5;
    localparam logic [2:0] c_ST_DONE      = 3'd6;
    localparam logic [2:0] c_ST_WAIT_IDLE = 3'd7;

    // Synchronizer and edge-detect history
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rxs_d;
    logic                 w_rxs;

    // Frame engine state
    logic [2:0]           r_state;
    logic [31:0]          r_timer;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_par_err;
    logic                 r_frm_err;

    // Frame configuration held from start detection to end of frame
    logic [31:0]          r_div;
    logic                 r_par_en;
    logic                 r_par_type;
    logic                 r_stop2;

    // Output buffer
    logic [DATA_BITS-1:0] r_data;
    logic                 r_data_par_err;
    logic                 r_data_frm_err;
    logic                 r_valid;
    logic                 r_overrun;

    logic [31:0]          w_div_clamped;
    logic                 w_tick;
    logic                 w_fall;

    assign w_rxs         = r_sync2;
    assign w_div_clamped = (clk_div_i < 32'(MIN_DIV)) ? 32'(MIN_DIV) : clk_div_i;
    assign w_tick        = (r_timer == 32'd0);
    assign w_fall        = r_rxs_d & ~w_rxs;

    // Two-flop synchronizer on the serial input plus one flop of history for start detection
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
            r_rxs_d <= r_sync2;
        end
    end

    // Frame FSM: bit timing, data shift, parity accumulation and stop-bit checks
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state    <= c_ST_IDLE;
            r_timer    <= 32'd0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_div      <= 32'd0;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_stop2    <= 1'b0;
        end else if (!clk_en_i) begin
            r_state   <= c_ST_IDLE;
            r_timer   <= 32'd0;
            r_bit_idx <= '0;
            r_par     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_fall) begin
                        r_state    <= c_ST_START;
                        r_timer    <= w_div_clamped >> 1;
                        r_div      <= w_div_clamped;
                        r_par_en   <= parity_en_i;
                        r_par_type <= parity_type_i;
                        r_stop2    <= stop_bits_i;
                        r_bit_idx  <= '0;
                        r_par      <= 1'b0;
                        r_par_err  <= 1'b0;
                        r_frm_err  <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (w_tick) begin
                        if (w_rxs) begin
                            // Line went back high: treat as a glitch, no frame
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_state <= c_ST_DATA;
                            r_timer <= r_div - 32'd1;
                        end
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                c_ST_DATA: begin
                    if (w_tick) begin
                        // LSB arrives first, so shift in from the top
                        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                        r_par   <= r_par ^ w_rxs;
                        r_timer <= r_div - 32'd1;
                        if (r_bit_idx == c_LAST_IDX) begin
                            r_bit_idx <= '0;
                            r_state   <= r_par_en ? c_ST_PARITY : c_ST_STOP1;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                        end
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                c_ST_PARITY: begin
                    if (w_tick) begin
                        r_par_err <= r_par ^ w_rxs ^ r_par_type;
                        r_timer   <= r_div - 32'd1;
                        r_state   <= c_ST_STOP1;
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                c_ST_STOP1: begin
                    if (w_tick) begin
                        if (!w_rxs) begin
                            r_frm_err <= 1'b1;
                        end
                        if (r_stop2) begin
                            r_timer <= r_div - 32'd1;
                            r_state <= c_ST_STOP2;
                        end else begin
                            r_state <= c_ST_DONE;
                        end
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                c_ST_STOP2: begin
                    if (w_tick) begin
                        if (!w_rxs) begin
                            r_frm_err <= 1'b1;
                        end
                        r_state <= c_ST_DONE;
                    end else begin
                        r_timer <= r_timer - 32'd1;
                    end
                end
                c_ST_DONE: begin
                    // After a framing error the line may be in break; wait for it to go high
                    r_state <= r_frm_err ? c_ST_WAIT_IDLE : c_ST_IDLE;
                end
                c_ST_WAIT_IDLE: begin
                    if (w_rxs) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // One-entry output buffer: load on frame completion, drop with overrun pulse when full
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_data         <= '0;
            r_data_par_err <= 1'b0;
            r_data_frm_err <= 1'b0;
            r_valid        <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
            if (clk_en_i && (r_state == c_ST_DONE)) begin
                // A transfer completing this cycle frees the slot for the new byte
                if (!r_valid || ready_i) begin
                    r_data         <= r_shift;
                    r_data_par_err <= r_par_err;
                    r_data_frm_err <= r_frm_err;
                    r_valid        <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign data_o       = r_data;
    assign parity_err_o = r_data_par_err;
    assign frame_err_o  = r_data_frm_err;
    assign valid_o      = r_valid;
    assign overrun_o    = r_overrun;
    assign busy_o       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Purpose  : Self-checking bench for uart_rx_core. Frames are built from
//            bit lists and expected results come from a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int MIN_DIV = 4;

    logic        clk = 1'b0;
    logic        arst_i;
    logic        clk_en_i;
    logic [31:0] clk_div_i;
    logic        parity_en_i;
    logic        parity_type_i;
    logic        stop_bits_i;
    logic        rx_i;
    logic [7:0]  data_o;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        valid_o;
    logic        ready_i;
    logic        overrun_o;
    logic        busy_o;

    uart_rx_core #(.DATA_BITS(8), .MIN_DIV(MIN_DIV)) dut (
        .clk_i        (clk),
        .arst_i       (arst_i),
        .clk_en_i     (clk_en_i),
        .clk_div_i    (clk_div_i),
        .parity_en_i  (parity_en_i),
        .parity_type_i(parity_type_i),
        .stop_bits_i  (stop_bits_i),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    // Monitor: valid edges, accepted entries, overrun pulses
    int          n_rise = 0;
    int          rise_cyc = 0;
    int          fall_cyc = 0;
    int          n_ovr = 0;
    logic        prev_valid = 1'b0;
    logic [9:0]  got_q[$];

    always @(negedge clk) begin
        if (valid_o && !prev_valid) begin
            n_rise++;
            rise_cyc = cyc;
        end
        if (!valid_o && prev_valid) fall_cyc = cyc;
        prev_valid = valid_o;
        if (valid_o && ready_i) got_q.push_back({frame_err_o, parity_err_o, data_o});
        if (overrun_o) n_ovr++;
    end

    // Details of the most recently sent frame
    int g_a;
    int g_div;
    int g_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: {frame_err, parity_err, data}
    function automatic logic [9:0] model(input logic [7:0] d, input bit pen, input bit ptype,
                                         input bit pflip, input bit stop_low);
        int  ones;
        bit  pbit;
        bit  perr;
        pbit = (^d) ^ ptype ^ pflip;
        ones = $countones(d) + int'(pbit);
        perr = pen && ((ones % 2) != int'(ptype));
        return {stop_low, perr, d};
    endfunction

    task automatic send_frame(input logic [7:0] d, input int dcfg, input bit pen, input bit ptype,
                              input bit st2, input bit pflip, input bit stop_low, input bit hold_low);
        int   de;
        logic bits[$];
        de = (dcfg < MIN_DIV) ? MIN_DIV : dcfg;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back((^d) ^ ptype ^ pflip);
        bits.push_back(!stop_low);
        if (st2) bits.push_back(!stop_low);
        clk_div_i     = 32'(dcfg);
        parity_en_i   = pen;
        parity_type_i = ptype;
        stop_bits_i   = st2;
        @(posedge clk); #1;
        g_a    = cyc;
        g_div  = de;
        g_last = bits.size() - 1;
        for (int i = 0; i < bits.size(); i++) begin
            rx_i = bits[i];
            // Mid-frame register writes must not disturb the frame in flight
            if (i == 3) begin
                clk_div_i     = 32'(dcfg + 7);
                parity_type_i = !ptype;
            end
            repeat (de) @(posedge clk);
            #1;
        end
        rx_i = hold_low ? 1'b0 : 1'b1;
    endtask

    task automatic wait_rise(input string tag, input int prior);
        for (int i = 0; i < 400 && n_rise == prior; i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_rise_seen"}, 64'(n_rise - prior), 64'd1);
        // sync(2) + detect(1) + half period + whole bit periods + sample/done(2)
        check({tag, "_rise_cyc"}, 64'(rise_cyc), 64'(g_a + 5 + (g_div >> 1) + g_last * g_div));
    endtask

    task automatic check_accepted(input string tag, input logic [9:0] exp);
        check({tag, "_entries"}, 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check({tag, "_entry"}, 64'(got_q[0]), 64'(exp));
        got_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          prior;
        int          a;
        logic [7:0]  d;
        int          dcfg;
        bit          pen, ptype, st2, pflip;

        arst_i = 1'b1; clk_en_i = 1'b1; clk_div_i = 32'd16; parity_en_i = 1'b0;
        parity_type_i = 1'b0; stop_bits_i = 1'b0; rx_i = 1'b1; ready_i = 1'b1;
        #23;
        check("reset_outputs", 64'({valid_o, overrun_o, busy_o, parity_err_o, frame_err_o, data_o}), 64'd0);
        @(posedge clk); #1; arst_i = 1'b0;
        repeat (4) @(posedge clk); #1;

        // 8N1, div 16, byte 0x55
        got_q.delete(); prior = n_rise;
        send_frame(8'h55, 16, 0, 0, 0, 0, 0, 0);
        wait_rise("b55", prior);
        check("b55_pulse_width", 64'(fall_cyc - rise_cyc), 64'd1);
        check_accepted("b55", model(8'h55, 0, 0, 0, 0));

        // Odd parity, wrong then correct parity bit
        prior = n_rise;
        send_frame(8'hA3, 16, 1, 1, 0, 1, 0, 0);
        wait_rise("a3_bad", prior);
        check_accepted("a3_bad", model(8'hA3, 1, 1, 1, 0));
        prior = n_rise;
        send_frame(8'hA3, 16, 1, 1, 0, 0, 0, 0);
        wait_rise("a3_good", prior);
        check_accepted("a3_good", model(8'hA3, 1, 1, 0, 0));

        // Start glitch: line low 6 cycles
        prior = n_rise;
        clk_div_i = 32'd16; parity_en_i = 1'b0; stop_bits_i = 1'b0;
        @(posedge clk); #1; a = cyc; rx_i = 1'b0;
        repeat (6) @(posedge clk); #1; rx_i = 1'b1;
        for (int i = 0; i < 40 && busy_o; i++) begin
            @(posedge clk); #1;
        end
        check("glitch_idle_cyc", 64'(cyc), 64'(a + 4 + 8));
        repeat (20) @(posedge clk); #1;
        check("glitch_no_valid", 64'(n_rise - prior), 64'd0);

        // Overrun: ready low, two bytes
        ready_i = 1'b0; got_q.delete(); prior = n_rise;
        send_frame(8'h11, 16, 0, 0, 0, 0, 0, 0);
        wait_rise("b11", prior);
        prior = n_ovr;
        send_frame(8'h22, 16, 0, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk); #1;
        check("overrun_pulses", 64'(n_ovr - prior), 64'd1);
        check("overrun_kept", 64'({valid_o, data_o}), 64'({1'b1, 8'h11}));
        ready_i = 1'b1;
        @(posedge clk); #1;
        check("overrun_drained_valid", 64'(valid_o), 64'd0);
        check_accepted("b11_drain", model(8'h11, 0, 0, 0, 0));
        prior = n_rise;
        send_frame(8'h33, 16, 0, 0, 0, 0, 0, 0);
        wait_rise("b33", prior);
        check_accepted("b33", model(8'h33, 0, 0, 0, 0));

        // Framing error with two stop bits, then a long break
        prior = n_rise;
        send_frame(8'h0F, 16, 0, 0, 1, 0, 1, 1);
        wait_rise("b0f", prior);
        check_accepted("b0f", model(8'h0F, 0, 0, 0, 1));
        prior = n_rise;
        repeat (100) @(posedge clk); #1;
        check("break_no_restart", 64'(n_rise - prior), 64'd0);
        check("break_busy", 64'(busy_o), 64'd1);
        rx_i = 1'b1;
        repeat (6) @(posedge clk); #1;
        check("break_released", 64'(busy_o), 64'd0);
        prior = n_rise;
        send_frame(8'h5A, 16, 0, 0, 0, 0, 0, 0);
        wait_rise("b5a", prior);
        check_accepted("b5a", model(8'h5A, 0, 0, 0, 0));

        // Randomized frames
        for (int n = 0; n < 8; n++) begin
            d     = 8'($urandom_range(0, 255));
            dcfg  = int'($urandom_range(0, 20));
            pen   = 1'($urandom_range(0, 1));
            ptype = 1'($urandom_range(0, 1));
            st2   = 1'($urandom_range(0, 1));
            pflip = 1'($urandom_range(0, 1));
            prior = n_rise;
            send_frame(d, dcfg, pen, ptype, st2, pflip, 0, 0);
            wait_rise("rand", prior);
            check_accepted("rand", model(d, pen, ptype, pflip, 0));
            repeat (2) @(posedge clk); #1;
        end

        // Clock enable low aborts a frame in flight
        clk_div_i = 32'd16; parity_en_i = 1'b0; stop_bits_i = 1'b0;
        prior = n_rise;
        @(posedge clk); #1; rx_i = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("clken_busy_before", 64'(busy_o), 64'd1);
        clk_en_i = 1'b0;
        @(posedge clk); #1;
        check("clken_busy_after", 64'(busy_o), 64'd0);
        rx_i = 1'b1;
        repeat (200) @(posedge clk); #1;
        check("clken_no_valid", 64'(n_rise - prior), 64'd0);
        clk_en_i = 1'b1;
        repeat (4) @(posedge clk); #1;

        // Asynchronous reset mid-DATA, with a byte held in the buffer
        ready_i = 1'b0; got_q.delete(); prior = n_rise;
        send_frame(8'h77, 16, 0, 0, 0, 0, 0, 0);
        wait_rise("b77", prior);
        @(posedge clk); #1; rx_i = 1'b0;
        repeat (30) @(posedge clk); #3;
        arst_i = 1'b1;
        #1;
        check("arst_outputs", 64'({valid_o, overrun_o, busy_o, parity_err_o, frame_err_o, data_o}), 64'd0);
        rx_i = 1'b1;
        repeat (3) @(posedge clk); #1;
        arst_i = 1'b0; ready_i = 1'b1;
        repeat (4) @(posedge clk); #1;
        got_q.delete(); prior = n_rise;
        send_frame(8'hC3, 1, 0, 0, 0, 0, 0, 0);
        wait_rise("bc3_div1", prior);
        check_accepted("bc3_div1", model(8'hC3, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
